// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int CTRL_W_DEF = 8;
  localparam int STALL_W    = 16;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage (main + inline skid register) with registered in_ready,
// synchronous flush and a saturating downstream-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 6,
  parameter int CTRL_W    = CTRL_W_DEF
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [STALL_W-1:0]          stall_cnt
);

  localparam int LANES_W = NUM_LANES * DATA_W;

  state_e               state_p0;
  state_e               state_nxt;
  logic [CTRL_W-1:0]    main_ctrl_p0;
  logic [LANES_W-1:0]   main_data_p0;
  logic [CTRL_W-1:0]    skid_ctrl_p0;
  logic [LANES_W-1:0]   skid_data_p0;
  logic                 in_ready_p0;
  logic [STALL_W-1:0]   stall_cnt_p0;
  logic                 vld_p0;

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign vld_p0    = (state_p0 != ST_EMPTY);
  assign out_valid = vld_p0;
  assign in_ready  = in_ready_p0;
  assign out_ctrl  = main_ctrl_p0;
  assign out_data  = main_data_p0;
  assign stall_cnt = stall_cnt_p0;

  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    in_xfer        = in_valid & in_ready_p0;
    out_xfer       = vld_p0 & out_ready;

    case (state_p0)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nxt    = ST_BUSY;
          load_main_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_xfer && !out_xfer) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (!in_xfer && out_xfer) begin
          state_nxt = ST_EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the downstream side can move
        if (out_xfer) begin
          state_nxt      = ST_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase

    if (Flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Stage p0: state, main and skid registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_p0     <= ST_EMPTY;
      in_ready_p0  <= 1'b0;
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      stall_cnt_p0 <= '0;
    end else begin
      state_p0    <= state_nxt;
      in_ready_p0 <= (state_nxt != ST_FULL);

      if (Flush) begin
        // flushed entries keep their lanes; only the control field is squashed
        main_ctrl_p0 <= '0;
        skid_ctrl_p0 <= '0;
      end else begin
        if (load_main_in) begin
          main_ctrl_p0 <= in_ctrl;
          main_data_p0 <= in_data;
        end else if (load_main_skid) begin
          main_ctrl_p0 <= skid_ctrl_p0;
          main_data_p0 <= skid_data_p0;
        end
        if (load_skid) begin
          skid_ctrl_p0 <= in_ctrl;
          skid_data_p0 <= in_data;
        end
      end

      if (vld_p0 && !out_ready)
        stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard checking every output transfer.
module tb_pipe_stage_reg;
  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 6;
  localparam int CTRL_W    = 8;
  localparam int LW        = DATA_W * NUM_LANES;
  localparam int EW        = CTRL_W + LW;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              Flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [LW-1:0]     in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [LW-1:0]     out_data;
  logic [15:0]       stall_cnt;

  logic [EW-1:0]     sb[$];
  int                n_asserts = 0;
  int                n_fail = 0;
  int                n_pops = 0;
  int                base;

  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build an entry: ctrl = low byte of v, lane i = v + i*0x1000_0000
  task automatic drive(input int v);
    in_valid = 1'b1;
    in_ctrl  = v[7:0];
    for (int i = 0; i < NUM_LANES; i++)
      in_data[i*DATA_W +: DATA_W] = v + i * 32'h1000_0000;
  endtask

  // Sample at the falling edge (what the next rising edge will commit), then move to posedge+1
  task automatic tick();
    logic [EW-1:0] exp;
    @(negedge Clk);
    if (Rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pops++;
        n_asserts++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("sb_entry", {out_ctrl, out_data}, exp);
        end
      end
      if (Flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // reset state
    #1 Rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    chk("in_ready_before_edge", in_ready, 0);
    tick();
    chk("in_ready_after_edge", in_ready, 1);

    // single entry, one-cycle latency
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = '0; in_data[31:0] = 32'h1234;
    tick();
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_ctrl", out_ctrl, 8'h5A);
    chk("lat_lane0", out_data[31:0], 32'h1234);
    chk("lat_stall0", stall_cnt, 0);
    tick();
    chk("stall_one", stall_cnt, 1);
    out_ready = 1'b1;
    tick();
    chk("lat_drained", out_valid, 0);

    // full-throughput stream 1..10
    base = n_pops;
    for (int v = 1; v <= 10; v++) begin
      drive(v);
      chk("stream_in_ready", in_ready, 1);
      tick();
      chk("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_pops", n_pops - base, 10);

    // back-pressure: fill to FULL, third held upstream
    out_ready = 1'b0;
    drive(21); tick();
    drive(22); tick();
    chk("full_in_ready", in_ready, 0);
    drive(23); tick(); tick();
    chk("full_in_ready_hold", in_ready, 0);
    chk("full_head", out_ctrl, 8'd21);
    out_ready = 1'b1;
    base = n_pops;
    tick();
    chk("full_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_pops", n_pops - base, 3);
    chk("bp_sb_empty", sb.size(), 0);

    // flush while FULL with an input offered
    out_ready = 1'b0;
    drive(31); tick();
    drive(32); tick();
    Flush = 1'b1; drive(33); tick();
    Flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    // flush while BUSY with an accepted-looking input
    drive(34); tick();
    Flush = 1'b1; drive(35); tick();
    Flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy_valid", out_valid, 0);
    out_ready = 1'b1;
    base = n_pops;
    repeat (3) tick();
    chk("flush_no_output", n_pops - base, 0);

    // stall counter saturation
    out_ready = 1'b0;
    drive(41); tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    chk("stall_sat", stall_cnt, 16'hFFFF);
    repeat (5) tick();
    chk("stall_sat_hold", stall_cnt, 16'hFFFF);

    // asynchronous reset mid-cycle while FULL
    drive(42); tick();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #2 Rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_data", out_data, 0);
    tick();
    Rst = 1'b0;
    out_ready = 1'b1;
    tick();
    base = n_pops;
    drive(51); tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("post_rst_pops", n_pops - base, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
